// File: rtl/id_branch_stage.sv
// ---------------------------------------------------------------------------
// id_branch_stage
//
// Decode-stage front end. Holds the instruction handed over by fetch, resolves
// branches locally, and returns a redirect {br_taken, br_target} to fetch.
// The surviving instruction is offered to execute. After every taken branch,
// fetch delivers exactly one wrong-path instruction, and this stage discards it.
//
// Ports
//   clk, reset        pipeline clock, asynchronous active-high reset
//   if_id_valid/bus   incoming {pc, inst} from fetch
//   id_allowin        decode can take a new instruction this cycle
//   id_if_bus         {br_taken, br_target} redirect to fetch
//   rf_raddr1/2       regfile read addresses (rj = inst[9:5], rd = inst[4:0])
//   rj_value/rkd_value combinational regfile read data
//   hazard_stall      operand not ready: keep the instruction in decode
//   ex_allowin        execute can accept
//   id_ex_valid/bus   {id_pc, id_inst} offered to execute
//   wb_ex, ertn_flush flush requests from writeback
//
// Handshake: a transfer across a stage boundary happens on a clock edge where
// the producer's valid and the consumer's allowin are both high. A producer
// never withdraws or changes an offered payload while it waits, except when
// a flush drops the payload.
// ---------------------------------------------------------------------------
module id_branch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_id_valid,
    input  logic [63:0] if_id_bus,
    output logic        id_allowin,
    output logic [32:0] id_if_bus,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rj_value,
    input  logic [31:0] rkd_value,
    input  logic        hazard_stall,
    input  logic        ex_allowin,
    output logic        id_ex_valid,
    output logic [63:0] id_ex_bus,
    input  logic        wb_ex,
    input  logic        ertn_flush
);

    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        cancel_pending;

    logic        flush;
    logic        id_ready_go;
    logic [5:0]  opcode;
    logic [31:0] off16_sext;
    logic [31:0] off26_sext;
    logic        is_branch;
    logic        br_cond;
    logic [31:0] br_dest;
    logic        br_taken;
    logic [31:0] br_target;

    assign flush       = wb_ex | ertn_flush;
    assign id_ready_go = ~hazard_stall;
    assign id_allowin  = ~id_valid | (id_ready_go & ex_allowin);
    assign id_ex_valid = id_valid & id_ready_go & ~flush;
    assign id_ex_bus   = {id_pc, id_inst};

    assign rf_raddr1 = id_inst[9:5];
    assign rf_raddr2 = id_inst[4:0];

    assign opcode     = id_inst[31:26];
    assign off16_sext = {{14{id_inst[25]}}, id_inst[25:10], 2'b00};
    // b/bl store the high offset bits in inst[9:0], above the inst[25:10] field
    assign off26_sext = {{4{id_inst[9]}}, id_inst[9:0], id_inst[25:10], 2'b00};

    always_comb begin
        is_branch = 1'b0;
        br_cond   = 1'b0;
        br_dest   = id_pc + off16_sext;
        case (opcode)
            6'h13: begin
                is_branch = 1'b1;
                br_cond   = 1'b1;
                br_dest   = rj_value + off16_sext;
            end
            6'h14, 6'h15: begin
                is_branch = 1'b1;
                br_cond   = 1'b1;
                br_dest   = id_pc + off26_sext;
            end
            6'h16: begin
                is_branch = 1'b1;
                br_cond   = (rj_value == rkd_value);
            end
            6'h17: begin
                is_branch = 1'b1;
                br_cond   = (rj_value != rkd_value);
            end
            6'h18: begin
                is_branch = 1'b1;
                br_cond   = ($signed(rj_value) < $signed(rkd_value));
            end
            6'h19: begin
                is_branch = 1'b1;
                br_cond   = ($signed(rj_value) >= $signed(rkd_value));
            end
            6'h1a: begin
                is_branch = 1'b1;
                br_cond   = (rj_value < rkd_value);
            end
            6'h1b: begin
                is_branch = 1'b1;
                br_cond   = (rj_value >= rkd_value);
            end
            default: begin
                is_branch = 1'b0;
                br_cond   = 1'b0;
            end
        endcase
    end

    // The redirect fires only in the cycle the branch actually leaves decode.
    // While it is stalled, the operands may still change, so it must not
    // commit early.
    assign br_taken  = id_valid & id_ready_go & ex_allowin & ~flush & is_branch & br_cond;
    assign br_target = br_taken ? br_dest : 32'h0;
    assign id_if_bus = {br_taken, br_target};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid       <= 1'b0;
            id_pc          <= 32'h0;
            id_inst        <= 32'h0;
            cancel_pending <= 1'b0;
        end else if (flush) begin
            id_valid       <= 1'b0;
            cancel_pending <= 1'b0;
        end else if (id_allowin & if_id_valid & (br_taken | cancel_pending)) begin
            // The arriving instruction is the wrong-path slot: drop it.
            id_valid       <= 1'b0;
            cancel_pending <= 1'b0;
        end else if (id_allowin & br_taken & ~if_id_valid) begin
            // The wrong-path slot has not arrived yet. Drop it when it shows up.
            id_valid       <= 1'b0;
            cancel_pending <= 1'b1;
        end else if (id_allowin) begin
            id_valid <= if_id_valid;
            if (if_id_valid) begin
                id_pc   <= if_id_bus[63:32];
                id_inst <= if_id_bus[31:0];
            end
        end
    end

endmodule

// File: tb/tb_id_branch_stage.sv
module tb_id_branch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_id_valid = 1'b0;
    logic [63:0] if_id_bus = 64'h0;
    logic        id_allowin;
    logic [32:0] id_if_bus;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rj_value = 32'h0;
    logic [31:0] rkd_value = 32'h0;
    logic        hazard_stall = 1'b0;
    logic        ex_allowin = 1'b1;
    logic        id_ex_valid;
    logic [63:0] id_ex_bus;
    logic        wb_ex = 1'b0;
    logic        ertn_flush = 1'b0;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    id_branch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .if_id_valid  (if_id_valid),
        .if_id_bus    (if_id_bus),
        .id_allowin   (id_allowin),
        .id_if_bus    (id_if_bus),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rj_value     (rj_value),
        .rkd_value    (rkd_value),
        .hazard_stall (hazard_stall),
        .ex_allowin   (ex_allowin),
        .id_ex_valid  (id_ex_valid),
        .id_ex_bus    (id_ex_bus),
        .wb_ex        (wb_ex),
        .ertn_flush   (ertn_flush)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural view of decode: is something held, what is it, and is the
    // next fetched slot known to be on the wrong path.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_inst = 32'h0;
    logic        m_cancel = 1'b0;

    // Returns {would_take, target} for an instruction, using plain arithmetic.
    function automatic logic [32:0] branch_of(input logic [31:0] pc, input logic [31:0] inst,
                                              input logic [31:0] a, input logic [31:0] b);
        int          o16;
        int          o26;
        int          sa;
        int          sb;
        logic        t;
        logic [31:0] tgt;
        o16 = int'(inst[25:10]);
        if (o16 >= 32768) o16 = o16 - 65536;
        o26 = int'({inst[9:0], inst[25:10]});
        if (o26 >= 33554432) o26 = o26 - 67108864;
        sa  = a;
        sb  = b;
        t   = 1'b0;
        tgt = pc + o16 * 4;
        case (inst[31:26])
            6'h13: begin t = 1'b1; tgt = a + o16 * 4; end
            6'h14: begin t = 1'b1; tgt = pc + o26 * 4; end
            6'h15: begin t = 1'b1; tgt = pc + o26 * 4; end
            6'h16: t = (a == b);
            6'h17: t = (a != b);
            6'h18: t = (sa < sb);
            6'h19: t = !(sa < sb);
            6'h1a: t = (a < b);
            6'h1b: t = !(a < b);
            default: t = 1'b0;
        endcase
        return {t, tgt};
    endfunction

    function automatic logic m_leaving();
        return m_valid && !hazard_stall && ex_allowin && !(wb_ex || ertn_flush);
    endfunction

    function automatic logic m_taken();
        logic [32:0] bi;
        bi = branch_of(m_pc, m_inst, rj_value, rkd_value);
        return m_leaving() && bi[32];
    endfunction

    function automatic logic m_allowin();
        return !m_valid || (!hazard_stall && ex_allowin);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid  = 1'b0;
            m_pc     = 32'h0;
            m_inst   = 32'h0;
            m_cancel = 1'b0;
        end else begin
            logic tk;
            tk = m_taken();
            if (wb_ex || ertn_flush) begin
                m_valid  = 1'b0;
                m_cancel = 1'b0;
            end else if (m_allowin()) begin
                if (if_id_valid) begin
                    if (tk || m_cancel) begin
                        m_valid  = 1'b0;
                        m_cancel = 1'b0;
                    end else begin
                        m_valid = 1'b1;
                        m_pc    = if_id_bus[63:32];
                        m_inst  = if_id_bus[31:0];
                    end
                end else begin
                    m_valid = 1'b0;
                    if (tk) m_cancel = 1'b1;
                end
            end
        end
    end

    // Compare every cycle, mid-cycle when all inputs and outputs are settled.
    always @(negedge clk) begin
        if (chk_on) begin
            logic [32:0] bi;
            logic [32:0] e_if;
            bi   = branch_of(m_pc, m_inst, rj_value, rkd_value);
            e_if = m_taken() ? {1'b1, bi[31:0]} : 33'h0;
            chk("m_allowin", {63'h0, id_allowin}, {63'h0, m_allowin()});
            chk("m_id_if_bus", {31'h0, id_if_bus}, {31'h0, e_if});
            chk("m_id_ex_valid", {63'h0, id_ex_valid},
                {63'h0, m_valid && !hazard_stall && !(wb_ex || ertn_flush)});
            chk("m_id_ex_bus", id_ex_bus, {m_pc, m_inst});
            chk("m_raddr", {54'h0, rf_raddr1, rf_raddr2}, {54'h0, m_inst[9:5], m_inst[4:0]});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        if_id_valid = v;
        if_id_bus   = {pc, inst};
    endtask

    task automatic idle_inputs();
        drv(1'b0, 32'h0, 32'h0);
        rj_value     = 32'h0;
        rkd_value    = 32'h0;
        hazard_stall = 1'b0;
        ex_allowin   = 1'b1;
        wb_ex        = 1'b0;
        ertn_flush   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset  = 1'b0;
        chk_on = 1'b1;
        #2;
        chk("rst_allowin", {63'h0, id_allowin}, 64'h1);
        chk("rst_id_if_bus", {31'h0, id_if_bus}, 64'h0);
        chk("rst_id_ex_valid", {63'h0, id_ex_valid}, 64'h0);
        chk("rst_id_ex_bus", id_ex_bus, 64'h0);

        // Taken beq: one-cycle redirect, wrong-path slot dropped
        drv(1'b1, 32'h1c000000, 32'h58001022);
        rj_value = 32'd5; rkd_value = 32'd5;
        step();
        drv(1'b1, 32'h1c000004, 32'h02800000);
        #2;
        chk("beq_taken", {31'h0, id_if_bus}, {31'h0, 1'b1, 32'h1c000010});
        chk("beq_raddr", {54'h0, rf_raddr1, rf_raddr2}, {54'h0, 5'd1, 5'd2});
        step();
        drv(1'b0, 32'h0, 32'h0);
        #2;
        chk("beq_pulse_end", {31'h0, id_if_bus}, 64'h0);
        chk("beq_wrongpath", {63'h0, id_ex_valid}, 64'h0);

        // Not-taken beq: next instruction passes
        do_reset();
        drv(1'b1, 32'h1c000000, 32'h58001022);
        rj_value = 32'd5; rkd_value = 32'd6;
        step();
        drv(1'b1, 32'h1c000004, 32'h02800000);
        #2;
        chk("beq_nt", {31'h0, id_if_bus}, 64'h0);
        step();
        drv(1'b0, 32'h0, 32'h0);
        #2;
        chk("beq_nt_next_valid", {63'h0, id_ex_valid}, 64'h1);
        chk("beq_nt_next_bus", id_ex_bus, {32'h1c000004, 32'h02800000});

        // b backward with no fetch in the branch cycle: cancel deferred
        do_reset();
        drv(1'b1, 32'h1c000100, 32'h53ffffff);
        step();
        drv(1'b0, 32'h0, 32'h0);
        #2;
        chk("b_back", {31'h0, id_if_bus}, {31'h0, 1'b1, 32'h1c0000fc});
        step();
        drv(1'b1, 32'h1c000104, 32'h02800000);
        #2;
        chk("b_empty", {63'h0, id_ex_valid}, 64'h0);
        step();
        drv(1'b1, 32'h1c000108, 32'h02800400);
        #2;
        chk("b_dropped", {63'h0, id_ex_valid}, 64'h0);
        step();
        drv(1'b0, 32'h0, 32'h0);
        #2;
        chk("b_after_valid", {63'h0, id_ex_valid}, 64'h1);
        chk("b_after_bus", id_ex_bus, {32'h1c000108, 32'h02800400});

        // jirl held by a 3-cycle hazard stall
        do_reset();
        drv(1'b1, 32'h1c000200, 32'h4c000820);
        rj_value = 32'h1c001000;
        step();
        drv(1'b0, 32'h0, 32'h0);
        hazard_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("jirl_stall_br", {31'h0, id_if_bus}, 64'h0);
            chk("jirl_stall_allowin", {63'h0, id_allowin}, 64'h0);
            step();
        end
        hazard_stall = 1'b0;
        #2;
        chk("jirl_taken", {31'h0, id_if_bus}, {31'h0, 1'b1, 32'h1c001008});
        step();
        #2;
        chk("jirl_pulse_end", {31'h0, id_if_bus}, 64'h0);

        // Flush beats a ready taken bne; no cancel left behind
        do_reset();
        drv(1'b1, 32'h1c000300, 32'h5c001022);
        rj_value = 32'd5; rkd_value = 32'd6;
        step();
        drv(1'b0, 32'h0, 32'h0);
        wb_ex = 1'b1;
        #2;
        chk("flush_br", {31'h0, id_if_bus}, 64'h0);
        chk("flush_exv", {63'h0, id_ex_valid}, 64'h0);
        step();
        wb_ex = 1'b0;
        drv(1'b1, 32'h1c000304, 32'h02800000);
        #2;
        chk("flush_empty", {63'h0, id_allowin, id_ex_valid}, 64'h2);
        step();
        drv(1'b0, 32'h0, 32'h0);
        #2;
        chk("flush_next_bus", {id_ex_valid ? id_ex_bus : 64'h0}, {32'h1c000304, 32'h02800000});

        // Asynchronous reset while a branch is stalled
        do_reset();
        drv(1'b1, 32'h1c000400, 32'h58001022);
        rj_value = 32'd5; rkd_value = 32'd5;
        step();
        drv(1'b0, 32'h0, 32'h0);
        hazard_stall = 1'b1;
        #2;
        chk("rst_mid_stall_allowin", {63'h0, id_allowin}, 64'h0);
        reset = 1'b1;
        #1;
        chk("rst_async_allowin", {63'h0, id_allowin}, 64'h1);
        chk("rst_async_outs", {id_if_bus, id_ex_valid, rf_raddr1, rf_raddr2},
            {33'h0, 1'b0, 5'd0, 5'd0});
        chk("rst_async_bus", id_ex_bus, 64'h0);
        step();
        reset = 1'b0;
        hazard_stall = 1'b0;
        drv(1'b1, 32'h1c000500, 32'h02800000);
        step();
        drv(1'b0, 32'h0, 32'h0);
        #2;
        chk("rst_no_cancel", {id_ex_valid ? id_ex_bus : 64'h0}, {32'h1c000500, 32'h02800000});

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rnd;
            logic [31:0] rpc;
            logic [5:0]  opc;
            int          r;
            step();
            rnd = $urandom();
            rpc = $urandom();
            r   = $urandom_range(0, 11);
            opc = (r <= 8) ? 6'(6'h13 + r) : 6'($urandom_range(0, 63));
            drv(($urandom_range(0, 9) < 7), {rpc[31:2], 2'b00}, {opc, rnd[25:0]});
            rj_value = $urandom();
            case ($urandom_range(0, 3))
                0: rkd_value = rj_value;
                1: rkd_value = $urandom_range(0, 3) - 2;
                default: rkd_value = $urandom();
            endcase
            hazard_stall = ($urandom_range(0, 4) == 0);
            ex_allowin   = ($urandom_range(0, 4) != 0);
            wb_ex        = ($urandom_range(0, 29) == 0);
            ertn_flush   = ($urandom_range(0, 29) == 0);
            reset        = ($urandom_range(0, 99) == 0);
        end
        step();
        reset = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
